// File: rtl/divider_meter.sv
// rtl/divider_meter.sv - measures sig_in half-periods and reports the matching divider load N
// Define DIVIDER_METER_CONTINUOUS_EN to re-arm after each result instead of returning to idle.
module divider_meter #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] load_out,
    output logic             mismatch,
    output logic             overflow
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [WIDTH:0]   LIMIT   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   ONE     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_OUT = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [WIDTH:0]         cnt_q;
    logic [WIDTH:0]         cnt_d;
    logic [WIDTH:0]         hi_q;
    logic                   busy_q;
    logic                   valid_q;
    logic [WIDTH-1:0]       load_q;
    logic                   mismatch_q;
    logic                   overflow_q;
    logic                   sync_lvl;
    logic                   rise;
    logic                   fall;
    logic                   edge_p;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~prev_q;
    assign fall     = ~sync_lvl & prev_q;
    assign edge_p   = rise | fall;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_lvl;
        end
    end

    // The count seen alongside an edge pulse is exactly the spacing to the previous edge.
    always_comb begin
        cnt_d = cnt_q + ONE;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (edge_p) begin
            cnt_d = ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            load_q     <= '0;
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (rise) begin
                        state_q <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        hi_q    <= cnt_q;
                        state_q <= S_LOW;
                    end else if (cnt_q == LIMIT) begin
                        load_q     <= '1;
                        overflow_q <= 1'b1;
                        mismatch_q <= 1'b0;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        // hi_q == 2^WIDTH has zero low bits, so the subtraction wraps to all ones.
                        load_q     <= hi_q[WIDTH-1:0] - ONE_OUT;
                        mismatch_q <= (hi_q != cnt_q);
                        overflow_q <= 1'b0;
                        valid_q    <= 1'b1;
`ifdef DIVIDER_METER_CONTINUOUS_EN
                        state_q    <= S_HIGH;
`else
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
`endif
                    end else if (cnt_q == LIMIT) begin
                        load_q     <= '1;
                        overflow_q <= 1'b1;
                        mismatch_q <= 1'b0;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign load_out = load_q;
    assign mismatch = mismatch_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_divider_meter.sv
// tb/tb_divider_meter.sv - randomized scoreboard bench for divider_meter
module tb_divider_meter;
    localparam int W   = 8;
    localparam int LIM = 1 << W;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic         sig_in;
    logic         start;
    logic         busy;
    logic         valid;
    logic [W-1:0] load_out;
    logic         mismatch;
    logic         overflow;

    divider_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .start    (start),
        .busy     (busy),
        .valid    (valid),
        .load_out (load_out),
        .mismatch (mismatch),
        .overflow (overflow)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int load;
        bit mm;
        bit ov;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_valid   = 0;
    int   cyc       = 0;
    int   hi_len    = 6;
    int   lo_len    = 6;
    bit   cont_mode = 1'b0;
    int   last_load;
    int   last_cyc;
    bit   last_mm;
    bit   last_ov;
    bit   last_busy;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: half-period lengths in clock cycles straight to the reported result.
    function automatic exp_t model(int hi, int lo);
        exp_t e;
        if (hi > LIM || lo > LIM) begin
            e.load = LIM - 1;
            e.mm   = 1'b0;
            e.ov   = 1'b1;
        end else begin
            e.load = hi - 1;
            e.mm   = (hi != lo);
            e.ov   = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk_in) cyc <= cyc + 1;

    // Square wave: each period picks up the current hi_len/lo_len at its rising edge.
    initial begin
        int h;
        int l;
        sig_in = 1'b0;
        forever begin
            @(negedge clk_in);
            h = hi_len;
            l = lo_len;
            sig_in = 1'b1;
            repeat (h) @(negedge clk_in);
            sig_in = 1'b0;
            repeat (l - 1) @(negedge clk_in);
        end
    end

    always @(negedge clk_in) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            exp_t e;
            n_valid++;
            last_load = load_out;
            last_mm   = mismatch;
            last_ov   = overflow;
            last_busy = busy;
            last_cyc  = cyc;
            if (!cont_mode) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: got valid=1 load_out=%0d expected no pending result", load_out);
                end else begin
                    e = sb.pop_front();
                    chk("load_out", int'(load_out), e.load);
                    chk("mismatch", int'(mismatch), int'(e.mm));
                    chk("overflow", int'(overflow), int'(e.ov));
                    chk("busy_at_valid", int'(busy), 0);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic measure(int hi, int lo, bit extra_start);
        int old_p;
        int bound;
        old_p  = hi_len + lo_len;
        hi_len = hi;
        lo_len = lo;
        repeat (old_p + hi + lo + 4) @(negedge clk_in);
        chk("busy_before_start", int'(busy), 0);
        sb.push_back(model(hi, lo));
        pulse_start();
        chk("busy_after_start", int'(busy), 1);
        if (extra_start) begin
            repeat (2) @(negedge clk_in);
            pulse_start();
        end
        bound = 3 * (hi + lo) + 2 * LIM + 20;
        while (sb.size() != 0 && bound > 0) begin
            @(negedge clk_in);
            #1;
            bound--;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL result_timeout: got no valid expected result for hi=%0d lo=%0d", hi, lo);
            sb.delete();
        end else begin
            @(negedge clk_in);
            chk("busy_after_valid", int'(busy), 0);
        end
    endtask

    task automatic wait_sig(bit level, int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_in);
            #1;
            if (sig_in == level) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL sig_wait: got sig_in=%0d expected %0d", sig_in, level);
        end
    endtask

    task automatic wait_valid(int bound, output bit ok);
        int n0;
        n0 = n_valid;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_in);
            #1;
            if (n_valid > n0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL valid_timeout: got %0d valids expected more than %0d", n_valid, n0);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_load_out"}, int'(load_out), 0);
        chk({tag, "_mismatch"}, int'(mismatch), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        bit ok;
        int hi;
        int lo;
        int pc;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk_in);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("idle_no_start_busy", int'(busy), 0);

`ifdef DIVIDER_METER_CONTINUOUS_EN
        cont_mode = 1'b1;
        hi_len = 4;
        lo_len = 4;
        repeat (30) @(negedge clk_in);
        pulse_start();
        wait_valid(100, ok);
        pc = last_cyc;
        for (int k = 0; k < 3; k++) begin
            wait_valid(100, ok);
            chk("cont_load", last_load, 3);
            chk("cont_mismatch", int'(last_mm), 0);
            chk("cont_busy", int'(last_busy), 1);
            chk("cont_spacing", last_cyc - pc, 8);
            pc = last_cyc;
        end
        hi_len = 8;
        lo_len = 8;
        wait_valid(100, ok);
        wait_valid(100, ok);
        chk("cont_change_load", last_load, 7);
        chk("cont_change_busy", int'(last_busy), 1);
        hi_len = 300;
        lo_len = 3;
        wait_valid(100, ok);
        wait_valid(2 * LIM + 50, ok);
        chk("cont_ovf_flag", int'(last_ov), 1);
        chk("cont_ovf_load", last_load, LIM - 1);
        @(negedge clk_in);
        chk("cont_ovf_busy", int'(busy), 0);
        cont_mode = 1'b0;
`else
        measure(6, 6, 1'b1);
        measure(1, 1, 1'b0);
        measure(4, 7, 1'b0);

        hi_len = 5;
        lo_len = 30;
        repeat (50) @(negedge clk_in);
        wait_sig(1'b1, 60, ok);
        wait_sig(1'b0, 60, ok);
        repeat (5) @(negedge clk_in);
        sb.push_back(model(5, 30));
        pulse_start();
        wait_sig(1'b1, 60, ok);
        wait_sig(1'b0, 60, ok);
        repeat (10) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (60) @(negedge clk_in);
        chk("post_reset_busy", int'(busy), 0);
        measure(10, 10, 1'b0);

        measure(300, 3, 1'b0);
        measure(3, 3, 1'b0);

        for (int k = 0; k < 8; k++) begin
            hi = $urandom_range(1, 20);
            lo = ($urandom_range(0, 2) == 0) ? hi : $urandom_range(1, 20);
            measure(hi, lo, 1'b0);
        end
`endif
        repeat (10) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end
endmodule
